jtag_tap_ctrl: RTL and testbench
================================

# jtag_tap_ctrl

IEEE 1149.1-style TAP controller that sequences the boundary-scan register (BSR) and internal scan register (ISR) chains wrapped around the s9234 core. It runs the 16-state TAP machine, holds the 2-bit instruction register, and generates per-chain capture/shift/update strobes. It also drives the `inst` bus consumed by the BSR wrapper and muxes the serial return path onto TDO. It sits between the chip-level JTAG pins and the scan-wrapped CUT.

## Interface
- No parameters; instruction encodings and state codes come from `jtag_pkg`.
- `TCLK` in 1: sole clock; all state updates on the rising edge.
- `TRST` in 1: reset, synchronous, active-high.
- `TMS` in 1: TAP mode select, sampled on the TCLK rising edge.
- `TDI` in 1: serial data in, routed to the IR, BYPASS, and the externally wired chain heads.
- `TDO_BSR` in 1: tail of the BSR chain.
- `TDO_ISR` in 1: tail of the ISR chain.
- `TDO` out 1: serial data out.
- `TDO_EN` out 1: high only in Shift-DR and Shift-IR.
- `inst` out 2: current (updated) instruction.
- `clockdr_bs`, `shiftdr_bs`, `updatedr_bs` out 1 each: BSR strobes.
- `clockdr_is`, `shiftdr_is`, `updatedr_is` out 1 each: ISR strobes.

## Operation
- TAP states: TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR, SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR.
- Transitions on TMS=0/1:
  - TLR→RTI/TLR; RTI→RTI/SEL_DR; SEL_DR→CAP_DR/SEL_IR; SEL_IR→CAP_IR/TLR.
  - CAP_x→SH_x/EX1_x; SH_x→SH_x/EX1_x; EX1_x→PA_x/UPD_x.
  - PA_x→PA_x/EX2_x; EX2_x→SH_x/UPD_x; UPD_x→RTI/SEL_DR.
- Instructions:
  - 2'b00 EXTEST selects BSR.
  - 2'b10 INTSCAN selects ISR.
  - 2'b11 BYPASS selects the 1-bit bypass register.
  - 2'b01 is BYPASS unless JTAG_IDCODE_EN is defined.
- IR shift register (2 bits):
  - Loads 2'b01 in CAP_IR.
  - In SH_IR, shifts right each cycle: TDI enters the MSB, the LSB drives TDO.
  - `inst` loads from it in UPD_IR only.
- Bypass register: loads 0 in CAP_DR; in SH_DR, loads TDI.
- Strobes are Moore decodes of the state register and are asserted only for the selected chain; the other chain's strobes stay 0.
  - `clockdr_*`=1 in CAP_DR and SH_DR.
  - `shiftdr_*`=1 in SH_DR.
  - `updatedr_*`=1 in UPD_DR.
- TDO mux:
  - SH_IR → IR LSB.
  - SH_DR → TDO_BSR, TDO_ISR, or bypass bit per `inst`.
  - Otherwise 0.
- TLR also forces `inst` to its reset instruction each cycle spent there.

## Timing
- TRST=1 at a rising edge → the next cycle has state=TLR, IR shift reg=2'b01, bypass=0, all strobes=0, TDO=0, TDO_EN=0.
- `inst` reset value: 2'b11, or 2'b01 with JTAG_IDCODE_EN.
- TRST dominates TMS. TRST mid-shift aborts with no update strobe, and no partial IR value reaches `inst`.
- Five consecutive TMS=1 edges from any state reach TLR.
- State latency: one TCLK per transition. A strobe is high for exactly the cycles the state register holds the decoding state; UPD_* lasts exactly one cycle.
- `inst` changes on the edge leaving UPD_IR and is stable through all DR states.
- TDO is combinational from registers and the selected chain tail, with no path from TMS.
- The BYPASS path gives one TCLK of TDI→TDO delay in SH_DR.

## Configuration
- `JTAG_IDCODE_EN` defined:
  - Adds a 32-bit IDCODE register (value `JTAG_IDCODE` in `jtag_pkg`, LSB=1) that loads in CAP_DR and shifts LSB-first with TDI into the MSB.
  - Instruction 2'b01 selects IDCODE; it is also the reset instruction.
  - Both chains' strobes are 0 under IDCODE.
- Undefined: no IDCODE register; 2'b01 decodes as BYPASS; reset instruction 2'b11.

## Structure
- `jtag_pkg` holds:
  - `tap_state_t` enum, 4-bit encoding.
  - Instruction localparams INST_EXTEST, INST_INTSCAN, INST_IDCODE, INST_BYPASS.
  - `JTAG_IDCODE` constant.
- Sub-module `jtag_tap_fsm` holds the state register and next-state logic and outputs the state. The top holds IR, bypass, IDCODE, strobe decode, and the TDO mux.

## Test plan
- Reset: TRST=1 for 1 cycle with TMS=0 → state TLR, `inst`=2'b11, all six strobes 0, TDO_EN=0.
- Reset with TMS: from SH_DR, TMS=1 ×5 → TLR on the 5th edge. TMS=1 ×4 → state is not TLR.
- IR load:
  - Sequence TMS 0,1,1,0,0 followed by TMS=0 with TDI=0 over 2 SH_IR cycles, then TMS 1,1 → TDO shows 1,0 during the shifts.
  - `inst` stays 2'b11 until the UPD_IR exit edge, then becomes 2'b00.
- EXTEST DR scan:
  - `clockdr_bs`=1 for CAP_DR plus N SH_DR cycles; `shiftdr_bs`=1 only in SH_DR; `updatedr_bs` pulses once.
  - All `*_is`=0.
  - TDO follows TDO_BSR.
- INTSCAN plus BYPASS:
  - With `inst`=2'b10, only `*_is` strobes fire and TDO follows TDO_ISR.
  - With `inst`=2'b11, a TDI pattern 1,0,1,1 appears on TDO delayed by one cycle, with a leading 0 from capture.
- Abort and IDCODE:
  - TRST asserted mid-SH_IR → `inst` keeps its prior value and `updatedr_*` never fires.
  - With JTAG_IDCODE_EN, after reset 32 SH_DR cycles return `JTAG_IDCODE` LSB-first.

Source files
------------

// File: rtl/jtag_pkg.sv
// Shared types and constants for the JTAG TAP controller.
// Optional IDCODE support is enabled with the JTAG_IDCODE_EN macro.
package jtag_pkg;

    localparam int unsigned IR_W     = 2;
    localparam int unsigned IDCODE_W = 32;

    typedef enum logic [3:0] {
        EX2_DR = 4'h0,
        EX1_DR = 4'h1,
        SH_DR  = 4'h2,
        PA_DR  = 4'h3,
        SEL_IR = 4'h4,
        UPD_DR = 4'h5,
        CAP_DR = 4'h6,
        SEL_DR = 4'h7,
        EX2_IR = 4'h8,
        EX1_IR = 4'h9,
        SH_IR  = 4'hA,
        PA_IR  = 4'hB,
        RTI    = 4'hC,
        UPD_IR = 4'hD,
        CAP_IR = 4'hE,
        TLR    = 4'hF
    } tap_state_t;

    // Per-chain data-register strobe bundle
    typedef struct packed {
        logic clockdr;
        logic shiftdr;
        logic updatedr;
    } dr_strobe_t;

    localparam logic [IR_W-1:0] INST_EXTEST  = 2'b00;
    localparam logic [IR_W-1:0] INST_IDCODE  = 2'b01;
    localparam logic [IR_W-1:0] INST_INTSCAN = 2'b10;
    localparam logic [IR_W-1:0] INST_BYPASS  = 2'b11;

    localparam logic [IR_W-1:0] IR_CAPTURE = 2'b01;

`ifdef JTAG_IDCODE_EN
    localparam logic [IR_W-1:0] INST_RESET = INST_IDCODE;
`else
    localparam logic [IR_W-1:0] INST_RESET = INST_BYPASS;
`endif

    localparam logic [IDCODE_W-1:0] JTAG_IDCODE = 32'h1923_403F;

    function automatic dr_strobe_t dr_decode(input tap_state_t st);
        dr_strobe_t s;
        s.clockdr  = (st == CAP_DR) || (st == SH_DR);
        s.shiftdr  = (st == SH_DR);
        s.updatedr = (st == UPD_DR);
        return s;
    endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// 16-state TAP state machine: state register and TMS-driven next-state logic.
module jtag_tap_fsm
    import jtag_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       tms_i,
    output tap_state_t state_o
);

    tap_state_t state_q;
    tap_state_t state_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= TLR;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            TLR:     state_d = tms_i ? TLR    : RTI;
            RTI:     state_d = tms_i ? SEL_DR : RTI;
            SEL_DR:  state_d = tms_i ? SEL_IR : CAP_DR;
            CAP_DR:  state_d = tms_i ? EX1_DR : SH_DR;
            SH_DR:   state_d = tms_i ? EX1_DR : SH_DR;
            EX1_DR:  state_d = tms_i ? UPD_DR : PA_DR;
            PA_DR:   state_d = tms_i ? EX2_DR : PA_DR;
            EX2_DR:  state_d = tms_i ? UPD_DR : SH_DR;
            UPD_DR:  state_d = tms_i ? SEL_DR : RTI;
            SEL_IR:  state_d = tms_i ? TLR    : CAP_IR;
            CAP_IR:  state_d = tms_i ? EX1_IR : SH_IR;
            SH_IR:   state_d = tms_i ? EX1_IR : SH_IR;
            EX1_IR:  state_d = tms_i ? UPD_IR : PA_IR;
            PA_IR:   state_d = tms_i ? EX2_IR : PA_IR;
            EX2_IR:  state_d = tms_i ? UPD_IR : SH_IR;
            UPD_IR:  state_d = tms_i ? SEL_DR : RTI;
            default: state_d = TLR;
        endcase
    end

    assign state_o = state_q;

endmodule

// File: rtl/jtag_tap_ctrl.sv
// JTAG TAP controller for the BSR/ISR-wrapped core: IR, BYPASS, strobes, TDO mux.
// Define JTAG_IDCODE_EN to add the 32-bit IDCODE register (instruction 2'b01).
module jtag_tap_ctrl
    import jtag_pkg::*;
(
    input  logic            TCLK,
    input  logic            TRST,
    input  logic            TMS,
    input  logic            TDI,
    input  logic            TDO_BSR,
    input  logic            TDO_ISR,
    output logic            TDO,
    output logic            TDO_EN,
    output logic [IR_W-1:0] inst,
    output logic            clockdr_bs,
    output logic            shiftdr_bs,
    output logic            updatedr_bs,
    output logic            clockdr_is,
    output logic            shiftdr_is,
    output logic            updatedr_is
);

    tap_state_t      state;
    logic [IR_W-1:0] ir_q, ir_d;
    logic [IR_W-1:0] inst_q, inst_d;
    logic            bypass_q, bypass_d;
    dr_strobe_t      dr_s;
    logic            sel_bsr, sel_isr;

    jtag_tap_fsm u_fsm (
        .clk_i   (TCLK),
        .rst_i   (TRST),
        .tms_i   (TMS),
        .state_o (state)
    );

    // Instruction path: capture/shift register, then the updated instruction
    always_comb begin
        ir_d   = ir_q;
        inst_d = inst_q;
        case (state)
            CAP_IR:  ir_d = IR_CAPTURE;
            SH_IR:   ir_d = {TDI, ir_q[IR_W-1:1]};
            default: ir_d = ir_q;
        endcase
        if (state == UPD_IR) begin
            inst_d = ir_q;
        end else if (state == TLR) begin
            inst_d = INST_RESET;
        end
    end

    always_comb begin
        bypass_d = bypass_q;
        if (state == CAP_DR) begin
            bypass_d = 1'b0;
        end else if (state == SH_DR) begin
            bypass_d = TDI;
        end
    end

    always_ff @(posedge TCLK) begin
        if (TRST) begin
            ir_q     <= IR_CAPTURE;
            inst_q   <= INST_RESET;
            bypass_q <= 1'b0;
        end else begin
            ir_q     <= ir_d;
            inst_q   <= inst_d;
            bypass_q <= bypass_d;
        end
    end

`ifdef JTAG_IDCODE_EN
    logic [IDCODE_W-1:0] idcode_q, idcode_d;

    always_comb begin
        idcode_d = idcode_q;
        if (state == CAP_DR) begin
            idcode_d = JTAG_IDCODE;
        end else if (state == SH_DR) begin
            idcode_d = {TDI, idcode_q[IDCODE_W-1:1]};
        end
    end

    always_ff @(posedge TCLK) begin
        if (TRST) begin
            idcode_q <= JTAG_IDCODE;
        end else begin
            idcode_q <= idcode_d;
        end
    end
`endif

    assign sel_bsr = (inst_q == INST_EXTEST);
    assign sel_isr = (inst_q == INST_INTSCAN);

    // Moore strobe decode, gated to the chain chosen by the instruction
    always_comb begin
        dr_s        = dr_decode(state);
        clockdr_bs  = sel_bsr & dr_s.clockdr;
        shiftdr_bs  = sel_bsr & dr_s.shiftdr;
        updatedr_bs = sel_bsr & dr_s.updatedr;
        clockdr_is  = sel_isr & dr_s.clockdr;
        shiftdr_is  = sel_isr & dr_s.shiftdr;
        updatedr_is = sel_isr & dr_s.updatedr;
    end

    // Serial return path; TMS only reaches TDO through the state register
    always_comb begin
        TDO    = 1'b0;
        TDO_EN = 1'b0;
        case (state)
            SH_IR: begin
                TDO_EN = 1'b1;
                TDO    = ir_q[0];
            end
            SH_DR: begin
                TDO_EN = 1'b1;
                case (inst_q)
                    INST_EXTEST:  TDO = TDO_BSR;
                    INST_INTSCAN: TDO = TDO_ISR;
`ifdef JTAG_IDCODE_EN
                    INST_IDCODE:  TDO = idcode_q[0];
`endif
                    default:      TDO = bypass_q;
                endcase
            end
            default: begin
                TDO    = 1'b0;
                TDO_EN = 1'b0;
            end
        endcase
    end

    assign inst = inst_q;

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Scoreboard bench for jtag_tap_ctrl: directed TMS/TDI vectors with hand-computed
// per-cycle expectations queued by the driver and checked by a negedge monitor.
module tb_jtag_tap_ctrl;

    logic       TCLK, TRST, TMS, TDI, TDO_BSR, TDO_ISR;
    logic       TDO, TDO_EN;
    logic [1:0] inst;
    logic       clockdr_bs, shiftdr_bs, updatedr_bs;
    logic       clockdr_is, shiftdr_is, updatedr_is;

`ifdef JTAG_IDCODE_EN
    localparam logic [1:0] R = 2'b01;
`else
    localparam logic [1:0] R = 2'b11;
`endif
    localparam logic [31:0] EXP_ID = 32'h1923_403F;

    localparam logic [5:0] S0 = 6'b000000;
    localparam logic [5:0] CB = 6'b100000;
    localparam logic [5:0] SB = 6'b110000;
    localparam logic [5:0] UB = 6'b001000;
    localparam logic [5:0] CI = 6'b000100;
    localparam logic [5:0] SI = 6'b000110;
    localparam logic [5:0] UI = 6'b000001;

    typedef struct {
        string      name;
        logic       en;
        logic       tdo;
        logic [1:0] inst;
        logic [5:0] strb;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    logic [5:0] strb;
    assign strb = {clockdr_bs, shiftdr_bs, updatedr_bs, clockdr_is, shiftdr_is, updatedr_is};

    jtag_tap_ctrl dut (
        .TCLK        (TCLK),
        .TRST        (TRST),
        .TMS         (TMS),
        .TDI         (TDI),
        .TDO_BSR     (TDO_BSR),
        .TDO_ISR     (TDO_ISR),
        .TDO         (TDO),
        .TDO_EN      (TDO_EN),
        .inst        (inst),
        .clockdr_bs  (clockdr_bs),
        .shiftdr_bs  (shiftdr_bs),
        .updatedr_bs (updatedr_bs),
        .clockdr_is  (clockdr_is),
        .shiftdr_is  (shiftdr_is),
        .updatedr_is (updatedr_is)
    );

    initial TCLK = 1'b0;
    always #5 TCLK = ~TCLK;

    // Monitor: each queued expectation describes the cycle after one rising edge
    always @(negedge TCLK) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if (TDO_EN !== e.en || TDO !== e.tdo || inst !== e.inst || strb !== e.strb) begin
                errors++;
                $display("FAIL %s: got en=%b tdo=%b inst=%b strb=%b, want en=%b tdo=%b inst=%b strb=%b",
                         e.name, TDO_EN, TDO, inst, strb, e.en, e.tdo, e.inst, e.strb);
            end
        end
    end

    task automatic st(input logic tms, input logic tdi, input logic en, input logic tdo,
                      input logic [1:0] ie, input logic [5:0] sb, input string nm);
        exp_t e;
        TMS = tms;
        TDI = tdi;
        @(posedge TCLK);
        e.name = nm;
        e.en   = en;
        e.tdo  = tdo;
        e.inst = ie;
        e.strb = sb;
        q.push_back(e);
        @(negedge TCLK);
        #1;
    endtask

    initial begin
        TRST = 1'b0; TMS = 1'b0; TDI = 1'b0; TDO_BSR = 1'b0; TDO_ISR = 1'b0;
        @(negedge TCLK); #1;

        TRST = 1'b1;
        st(0, 0, 0, 0, R, S0, "reset");
        TRST = 1'b0;

`ifdef JTAG_IDCODE_EN
        st(0, 0, 0, 0, R, S0, "id_rti");
        st(1, 0, 0, 0, R, S0, "id_sel");
        st(0, 0, 0, 0, R, S0, "id_cap");
        for (int i = 0; i < 32; i++) begin
            st(0, 0, 1, EXP_ID[i], R, S0, $sformatf("id_bit%0d", i));
        end
        st(1, 0, 0, 0, R, S0, "id_ex1");
        st(1, 0, 0, 0, R, S0, "id_upd");
        st(0, 0, 0, 0, R, S0, "id_rti2");
`endif

        // Load EXTEST: capture 01, shift in 0,0
        st(0, 0, 0, 0, R, S0, "rti");
        st(1, 0, 0, 0, R, S0, "sel_dr");
        st(1, 0, 0, 0, R, S0, "sel_ir");
        st(0, 0, 0, 0, R, S0, "cap_ir");
        st(0, 0, 1, 1, R, S0, "sh_ir0");
        st(0, 0, 1, 0, R, S0, "sh_ir1");
        st(1, 0, 0, 0, R, S0, "ex1_ir");
        st(1, 0, 0, 0, R, S0, "upd_ir_hold");
        st(0, 0, 0, 0, 2'b00, S0, "inst_extest");

        // EXTEST DR scan, TDO follows BSR tail (ISR held opposite)
        st(1, 0, 0, 0, 2'b00, S0, "x_sel");
        st(0, 0, 0, 0, 2'b00, CB, "x_cap");
        TDO_BSR = 1; TDO_ISR = 0;
        st(0, 0, 1, 1, 2'b00, SB, "x_sh0");
        TDO_BSR = 0; TDO_ISR = 1;
        st(0, 0, 1, 0, 2'b00, SB, "x_sh1");
        TDO_BSR = 1; TDO_ISR = 0;
        st(0, 0, 1, 1, 2'b00, SB, "x_sh2");
        st(1, 0, 0, 0, 2'b00, S0, "x_ex1");
        st(1, 0, 0, 0, 2'b00, UB, "x_upd");
        st(0, 0, 0, 0, 2'b00, S0, "x_rti");

        // Load INTSCAN: shift in 0 then 1
        st(1, 0, 0, 0, 2'b00, S0, "i_sel_dr");
        st(1, 0, 0, 0, 2'b00, S0, "i_sel_ir");
        st(0, 0, 0, 0, 2'b00, S0, "i_cap_ir");
        st(0, 0, 1, 1, 2'b00, S0, "i_sh0");
        st(0, 0, 1, 0, 2'b00, S0, "i_sh1");
        st(1, 1, 0, 0, 2'b00, S0, "i_ex1");
        st(1, 0, 0, 0, 2'b00, S0, "i_upd");
        st(0, 0, 0, 0, 2'b10, S0, "inst_intscan");

        // INTSCAN DR scan, TDO follows ISR tail
        st(1, 0, 0, 0, 2'b10, S0, "is_sel");
        st(0, 0, 0, 0, 2'b10, CI, "is_cap");
        TDO_ISR = 1; TDO_BSR = 0;
        st(0, 0, 1, 1, 2'b10, SI, "is_sh0");
        TDO_ISR = 0; TDO_BSR = 1;
        st(0, 0, 1, 0, 2'b10, SI, "is_sh1");
        st(1, 1, 0, 0, 2'b10, S0, "is_ex1");
        st(1, 0, 0, 0, 2'b10, UI, "is_upd");
        st(0, 0, 0, 0, 2'b10, S0, "is_rti");

        // Load BYPASS: shift in 1,1
        st(1, 0, 0, 0, 2'b10, S0, "b_sel_dr");
        st(1, 0, 0, 0, 2'b10, S0, "b_sel_ir");
        st(0, 0, 0, 0, 2'b10, S0, "b_cap_ir");
        st(0, 0, 1, 1, 2'b10, S0, "b_sh0");
        st(0, 1, 1, 0, 2'b10, S0, "b_sh1");
        st(1, 1, 0, 0, 2'b10, S0, "b_ex1");
        st(1, 0, 0, 0, 2'b10, S0, "b_upd");
        st(0, 0, 0, 0, 2'b11, S0, "inst_bypass");

        // BYPASS: TDI 1,0,1,1 returns one cycle later behind a captured 0
        TDO_BSR = 1; TDO_ISR = 1;
        st(1, 0, 0, 0, 2'b11, S0, "by_sel");
        st(0, 0, 0, 0, 2'b11, S0, "by_cap");
        st(0, 0, 1, 0, 2'b11, S0, "by_lead0");
        st(0, 1, 1, 1, 2'b11, S0, "by_d0");
        st(0, 0, 1, 0, 2'b11, S0, "by_d1");
        st(0, 1, 1, 1, 2'b11, S0, "by_d2");
        st(0, 1, 1, 1, 2'b11, S0, "by_d3");
        st(1, 0, 0, 0, 2'b11, S0, "by_ex1");
        st(1, 0, 0, 0, 2'b11, S0, "by_upd");
        st(0, 0, 0, 0, 2'b11, S0, "by_rti");

        // Abort mid-SH_IR with partial value 00 in the shift register
        st(1, 0, 0, 0, 2'b11, S0, "a_sel_dr");
        st(1, 0, 0, 0, 2'b11, S0, "a_sel_ir");
        st(0, 0, 0, 0, 2'b11, S0, "a_cap_ir");
        st(0, 0, 1, 1, 2'b11, S0, "a_sh0");
        st(0, 0, 1, 0, 2'b11, S0, "a_sh1");
        TRST = 1'b1;
        st(1, 0, 0, 0, R, S0, "a_trst");
        TRST = 1'b0;
        st(1, 0, 0, 0, R, S0, "a_tlr");
        st(0, 0, 0, 0, R, S0, "a_rti");
        st(0, 0, 0, 0, R, S0, "a_rti2");

        // Reload EXTEST for the TMS-reset tests
        st(1, 0, 0, 0, R, S0, "t_sel_dr");
        st(1, 0, 0, 0, R, S0, "t_sel_ir");
        st(0, 0, 0, 0, R, S0, "t_cap_ir");
        st(0, 0, 1, 1, R, S0, "t_sh0");
        st(0, 0, 1, 0, R, S0, "t_sh1");
        st(1, 0, 0, 0, R, S0, "t_ex1");
        st(1, 0, 0, 0, R, S0, "t_upd");
        st(0, 0, 0, 0, 2'b00, S0, "t_inst");

        // From SH_DR four TMS=1 edges must not reach TLR
        TDO_BSR = 1; TDO_ISR = 0;
        st(1, 0, 0, 0, 2'b00, S0, "t4_sel");
        st(0, 0, 0, 0, 2'b00, CB, "t4_cap");
        st(0, 0, 1, 1, 2'b00, SB, "t4_sh");
        st(1, 0, 0, 0, 2'b00, S0, "t4_1");
        st(1, 0, 0, 0, 2'b00, UB, "t4_2");
        st(1, 0, 0, 0, 2'b00, S0, "t4_3");
        st(1, 0, 0, 0, 2'b00, S0, "t4_4");
        st(0, 0, 0, 0, 2'b00, S0, "t4_cap_ir");
        st(0, 0, 1, 1, 2'b00, S0, "t4_not_tlr");
        st(1, 0, 0, 0, 2'b00, S0, "t4_ex1_ir");
        st(1, 0, 0, 0, 2'b00, S0, "t4_upd_ir");
        st(0, 0, 0, 0, 2'b00, S0, "t4_rti");

        // From SH_DR five TMS=1 edges reach TLR, which then forces the reset instruction
        st(1, 0, 0, 0, 2'b00, S0, "t5_sel");
        st(0, 0, 0, 0, 2'b00, CB, "t5_cap");
        st(0, 0, 1, 1, 2'b00, SB, "t5_sh");
        st(1, 0, 0, 0, 2'b00, S0, "t5_1");
        st(1, 0, 0, 0, 2'b00, UB, "t5_2");
        st(1, 0, 0, 0, 2'b00, S0, "t5_3");
        st(1, 0, 0, 0, 2'b00, S0, "t5_4");
        st(1, 0, 0, 0, 2'b00, S0, "t5_5_tlr");
        st(1, 0, 0, 0, R, S0, "t5_tlr_inst");
        st(0, 0, 0, 0, R, S0, "t5_rti");

        @(negedge TCLK); #1;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
